// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - pipeline-to-mem_system load/store request controller
// Optional hit/miss performance counters: MEM_PERF_CNT_EN
module mem_req_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_rd,
  input  logic        pipe_wr,
  input  logic [15:0] pipe_addr,
  input  logic [15:0] pipe_wdata,
  output logic        pipe_stall,
  output logic [15:0] pipe_rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_datain,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_dataout,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        mem_hit,
  input  logic        mem_err,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       op_rd, op_wr;
  logic [7:0] tmo_cnt;
  logic       latch_req, capture, go_err, tmo_clr, tmo_inc;

  always_comb begin
    state_nxt = state;
    latch_req = 1'b0;
    capture   = 1'b0;
    go_err    = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (pipe_rd | pipe_wr) begin
          if (pipe_addr[0] | (pipe_rd & pipe_wr)) begin
            go_err    = 1'b1;
            state_nxt = ERR;
          end else begin
            latch_req = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        // mem_err wins over a same-cycle done
        if (mem_err) begin
          go_err    = 1'b1;
          state_nxt = ERR;
        end else if (!mem_stall) begin
          if (mem_done) begin
            capture   = 1'b1;
            state_nxt = RESP;
          end else begin
            tmo_clr   = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_err) begin
          go_err    = 1'b1;
          state_nxt = ERR;
        end else if (mem_done) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          go_err    = 1'b1;
          state_nxt = ERR;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      op_rd      <= 1'b0;
      op_wr      <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_datain <= 16'h0000;
      pipe_rdata <= 16'h0000;
      err        <= 1'b0;
      tmo_cnt    <= 8'h00;
    end else begin
      state <= state_nxt;
      if (latch_req) begin
        op_rd      <= pipe_rd;
        op_wr      <= pipe_wr;
        mem_addr   <= pipe_addr;
        mem_datain <= pipe_wdata;
      end
      if (capture) pipe_rdata <= mem_dataout;
      if (go_err) err <= 1'b1;
      if (tmo_clr) tmo_cnt <= 8'h00;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + 8'h01;
    end
  end

  assign pipe_stall  = ((state == IDLE) & (pipe_rd | pipe_wr)) | (state == ISSUE) |
                       (state == WAIT) | (state == ERR);
  assign mem_rd      = (state == ISSUE) & op_rd & ~mem_stall;
  assign mem_wr      = (state == ISSUE) & op_wr & ~mem_stall;
  assign rdata_valid = (state == RESP) & op_rd;

`ifdef MEM_PERF_CNT_EN
  logic in_flight;
  assign in_flight = (state == ISSUE) | (state == WAIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else if (in_flight & mem_done) begin
      if (mem_hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'h0001;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'h0001;
      end
    end
  end
`else
  logic unused_hit;
  assign unused_hit = mem_hit;
  assign hit_cnt    = 16'h0000;
  assign miss_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed self-checking bench for mem_req_ctrl
module tb_mem_req_ctrl;

`ifdef MEM_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_rd, pipe_wr;
  logic [15:0] pipe_addr, pipe_wdata;
  logic [15:0] mem_dataout;
  logic        mem_done, mem_stall, mem_hit, mem_err;

  logic        pipe_stall, rdata_valid, err, mem_rd, mem_wr;
  logic [15:0] pipe_rdata, mem_addr, mem_datain, hit_cnt, miss_cnt;

  logic        pipe_stall_t, rdata_valid_t, err_t, mem_rd_t, mem_wr_t;
  logic [15:0] pipe_rdata_t, mem_addr_t, mem_datain_t, hit_cnt_t, miss_cnt_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  int n_valid  = 0;
  int base;

  always #5 clk = ~clk;

  mem_req_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata), .rdata_valid(rdata_valid), .err(err),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dataout(mem_dataout), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_hit(mem_hit), .mem_err(mem_err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  mem_req_ctrl #(.TIMEOUT(4)) dut_tmo (
    .clk(clk), .rst(rst),
    .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall_t), .pipe_rdata(pipe_rdata_t), .rdata_valid(rdata_valid_t),
    .err(err_t), .mem_addr(mem_addr_t), .mem_datain(mem_datain_t), .mem_rd(mem_rd_t),
    .mem_wr(mem_wr_t), .mem_dataout(mem_dataout), .mem_done(mem_done),
    .mem_stall(mem_stall), .mem_hit(mem_hit), .mem_err(mem_err),
    .hit_cnt(hit_cnt_t), .miss_cnt(miss_cnt_t)
  );

  always @(negedge clk) begin
    if (mem_rd) n_rd++;
    if (mem_wr) n_wr++;
    if (rdata_valid) n_valid++;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] perf(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst = 1'b0; pipe_rd = 1'b0; pipe_wr = 1'b0; pipe_addr = 16'h0; pipe_wdata = 16'h0;
    mem_dataout = 16'h0; mem_done = 1'b0; mem_stall = 1'b0; mem_hit = 1'b0; mem_err = 1'b0;
    nxt; nxt;
    expect_eq("rst_stall", pipe_stall, 0);
    expect_eq("rst_err", err, 0);
    expect_eq("rst_memrd", mem_rd, 0);
    expect_eq("rst_memwr", mem_wr, 0);
    expect_eq("rst_addr", mem_addr, 0);
    expect_eq("rst_rdata", pipe_rdata, 0);
    expect_eq("rst_valid", rdata_valid, 0);
    expect_eq("rst_hit", hit_cnt, 0);
    expect_eq("rst_miss", miss_cnt, 0);
    rst = 1'b1;

    // load hit
    nxt; pipe_rd = 1'b1; pipe_addr = 16'h0010; #1;
    expect_eq("hit_idle_stall", pipe_stall, 1);
    expect_eq("hit_idle_memrd", mem_rd, 0);
    nxt; mem_done = 1'b1; mem_hit = 1'b1; mem_dataout = 16'hBEEF; #1;
    expect_eq("hit_pulse", mem_rd, 1);
    expect_eq("hit_pulse_stall", pipe_stall, 1);
    expect_eq("hit_addr", mem_addr, 16'h0010);
    nxt; mem_done = 1'b0; mem_hit = 1'b0; #1;
    expect_eq("hit_resp_stall", pipe_stall, 0);
    expect_eq("hit_valid", rdata_valid, 1);
    expect_eq("hit_rdata", pipe_rdata, 16'hBEEF);
    expect_eq("hit_resp_memrd", mem_rd, 0);
    expect_eq("hit_cnt1", hit_cnt, perf(1));
    nxt; pipe_rd = 1'b0; #1;
    expect_eq("hit_after_valid", rdata_valid, 0);
    expect_eq("hit_after_stall", pipe_stall, 0);
    expect_eq("hit_nrd", n_rd, 1);

    // store miss, done 5 cycles after the pulse
    nxt; pipe_wr = 1'b1; pipe_addr = 16'h0400; pipe_wdata = 16'h1234; #1;
    expect_eq("st_idle_stall", pipe_stall, 1);
    nxt; #1;
    expect_eq("st_pulse", mem_wr, 1);
    expect_eq("st_datain", mem_datain, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      nxt; #1;
      expect_eq("st_wait_memwr", mem_wr, 0);
      expect_eq("st_wait_stall", pipe_stall, 1);
    end
    nxt; mem_done = 1'b1; #1;
    expect_eq("st_done_stall", pipe_stall, 1);
    nxt; mem_done = 1'b0; #1;
    expect_eq("st_resp_stall", pipe_stall, 0);
    expect_eq("st_resp_valid", rdata_valid, 0);
    expect_eq("st_miss_cnt", miss_cnt, perf(1));
    nxt; pipe_wr = 1'b0; #1;
    expect_eq("st_nwr", n_wr, 1);
    expect_eq("st_nvalid", n_valid, 1);

    // busy memory: 3 stalled ISSUE cycles
    nxt; pipe_rd = 1'b1; pipe_addr = 16'h0020; mem_stall = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      nxt; #1;
      expect_eq("busy_memrd", mem_rd, 0);
      expect_eq("busy_stall", pipe_stall, 1);
    end
    nxt; mem_stall = 1'b0; mem_done = 1'b1; mem_hit = 1'b1; mem_dataout = 16'h5A5A; #1;
    expect_eq("busy_pulse", mem_rd, 1);
    nxt; mem_done = 1'b0; mem_hit = 1'b0; #1;
    expect_eq("busy_valid", rdata_valid, 1);
    expect_eq("busy_rdata", pipe_rdata, 16'h5A5A);
    expect_eq("busy_hit_cnt", hit_cnt, perf(2));
    nxt; pipe_rd = 1'b0; #1;
    expect_eq("busy_nrd", n_rd, 2);

    // mem_err ignored in IDLE
    nxt; mem_err = 1'b1; #1;
    nxt; mem_err = 1'b0; #1;
    expect_eq("idle_memerr", err, 0);

    // misalign
    nxt; pipe_rd = 1'b1; pipe_addr = 16'h0003; #1;
    expect_eq("mis_stall", pipe_stall, 1);
    nxt; pipe_rd = 1'b0; #1;
    expect_eq("mis_err", err, 1);
    for (int i = 0; i < 5; i++) begin
      nxt; #1;
      expect_eq("mis_hold_stall", pipe_stall, 1);
      expect_eq("mis_hold_err", err, 1);
    end
    expect_eq("mis_nrd", n_rd, 2);
    rst = 1'b0;
    nxt; #1;
    expect_eq("mis_rst_err", err, 0);
    expect_eq("mis_rst_stall", pipe_stall, 0);
    rst = 1'b1;

    // both ops high is illegal
    nxt; pipe_rd = 1'b1; pipe_wr = 1'b1; pipe_addr = 16'h0010; #1;
    nxt; pipe_rd = 1'b0; pipe_wr = 1'b0; #1;
    expect_eq("both_err", err, 1);
    expect_eq("both_memrd", mem_rd, 0);
    rst = 1'b0; nxt; rst = 1'b1;

    // mem_err in WAIT
    nxt; pipe_rd = 1'b1; pipe_addr = 16'h0050; #1;
    nxt; #1;
    nxt; mem_err = 1'b1; #1;
    expect_eq("merr_pre", err, 0);
    nxt; mem_err = 1'b0; pipe_rd = 1'b0; #1;
    expect_eq("merr_err", err, 1);
    rst = 1'b0; nxt; rst = 1'b1;

    // watchdog on the TIMEOUT=4 instance
    nxt; pipe_rd = 1'b1; pipe_addr = 16'h0030; #1;
    nxt; #1;
    expect_eq("tmo_pulse", mem_rd_t, 1);
    for (int i = 0; i < 4; i++) begin
      nxt; #1;
      expect_eq("tmo_wait_err", err_t, 0);
      expect_eq("tmo_wait_stall", pipe_stall_t, 1);
    end
    nxt; #1;
    expect_eq("tmo_err", err_t, 1);
    expect_eq("tmo_main_err", err, 0);
    pipe_rd = 1'b0; rst = 1'b0;
    nxt; #1;
    expect_eq("tmo_rst_err", err_t, 0);
    expect_eq("tmo_rst_stall", pipe_stall_t, 0);
    expect_eq("tmo_rst_addr", mem_addr_t, 0);
    expect_eq("tmo_rst_rdata", pipe_rdata_t, 0);
    expect_eq("tmo_rst_valid", rdata_valid_t, 0);
    expect_eq("tmo_rst_memrd", mem_rd_t, 0);
    expect_eq("tmo_rst_hit", hit_cnt_t, 0);
    rst = 1'b1;

    // back-to-back loads
    base = n_valid;
    nxt; pipe_rd = 1'b1; pipe_addr = 16'h0040; #1;
    nxt; mem_done = 1'b1; mem_hit = 1'b1; mem_dataout = 16'h1111; #1;
    expect_eq("b2b_pulse1", mem_rd, 1);
    expect_eq("b2b_addr1", mem_addr, 16'h0040);
    nxt; mem_done = 1'b0; mem_hit = 1'b0; pipe_addr = 16'h0042; #1;
    expect_eq("b2b_valid1", rdata_valid, 1);
    expect_eq("b2b_rdata1", pipe_rdata, 16'h1111);
    nxt; #1;
    expect_eq("b2b_idle_memrd", mem_rd, 0);
    expect_eq("b2b_idle_stall", pipe_stall, 1);
    expect_eq("b2b_idle_valid", rdata_valid, 0);
    nxt; mem_done = 1'b1; mem_hit = 1'b1; mem_dataout = 16'h2222; #1;
    expect_eq("b2b_pulse2", mem_rd, 1);
    expect_eq("b2b_addr2", mem_addr, 16'h0042);
    nxt; mem_done = 1'b0; mem_hit = 1'b0; #1;
    expect_eq("b2b_valid2", rdata_valid, 1);
    expect_eq("b2b_rdata2", pipe_rdata, 16'h2222);
    expect_eq("b2b_hit_cnt", hit_cnt, perf(2));
    nxt; pipe_rd = 1'b0; #1;
    expect_eq("b2b_after_valid", rdata_valid, 0);
    expect_eq("b2b_nvalid", n_valid - base, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
